// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 cascade / INTA sequencer.
package pic_pkg;

    // Default cascade bus width (8 IRs).
    localparam int CASC_W_DEF = 3;

    // Byte selected for the data bus during an INTA pulse.
    localparam logic [1:0] VSEL_CALL = 2'd0;
    localparam logic [1:0] VSEL_LO   = 2'd1;
    localparam logic [1:0] VSEL_HI   = 2'd2;

    // INTA sequencer states: P = inside a pulse, G = gap after a pulse.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4,
        P3   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/pic_inta_edge.sv
// Registers the INTA strobe once and flags its falling and rising edges.
module pic_inta_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_inta_n,
    output logic o_fall,
    output logic o_rise
);

    logic r_inta_q;

    // Delay INTA by one cycle; the reset value is the strobe's inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inta_q <= 1'b1;
        end else begin
            r_inta_q <= i_inta_n;
        end
    end

    assign o_fall = r_inta_q & ~i_inta_n;
    assign o_rise = ~r_inta_q & i_inta_n;

endmodule

// File: rtl/pic_cascade_seq.sv
// INTA handshake sequencer for the 8259 cascade: drives the CAS bus as a
// master, matches it as a slave, and decides which device supplies each
// vector byte in 8086 (2-pulse) and 8080/85 (3-pulse) modes.
module pic_cascade_seq
    import pic_pkg::*;
#(
    parameter int CASC_W  = CASC_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sp,
    input  logic                 sngl,
    input  logic                 mode_8086,
    input  logic [2**CASC_W-1:0] icw3,
    input  logic [CASC_W-1:0]    intr_id,
    input  logic                 inta_n,
    input  logic [CASC_W-1:0]    casc_in,
    output logic [CASC_W-1:0]    casc_out,
    output logic                 casc_oe,
    output logic                 vec_en,
    output logic [1:0]           vec_sel,
    output logic                 seq_active,
    output logic                 seq_done,
    output logic                 seq_abort
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic w_fall;
    logic w_rise;
    logic w_casc_now;
    logic w_match_now;
    logic w_resp;

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_seq_8086;
    logic              r_seq_sp;
    logic              r_seq_sngl;
    logic              r_casc;
    logic              r_match;
    logic [CASC_W-1:0] r_casc_out;
    logic              r_casc_oe;
    logic              r_vec_en;
    logic [1:0]        r_vec_sel;
    logic              r_seq_active;
    logic              r_seq_done;
    logic              r_seq_abort;

    pic_inta_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .i_inta_n (inta_n),
        .o_fall   (w_fall),
        .o_rise   (w_rise)
    );

    // Live decisions, only consumed on the edge that starts a sequence.
    assign w_casc_now  = sp & ~sngl & icw3[intr_id];
    assign w_match_now = ~sp & ~sngl & (casc_in == icw3[CASC_W-1:0]);

    // Who supplies the vector/address bytes, from the latched sequence context.
    assign w_resp = r_seq_sngl | (r_seq_sp ? ~r_casc : r_match);

    // Sequencer FSM with registered outputs; r_casc_out doubles as the latched ID.
    always_ff @(posedge clk) begin
        logic to_idle;
        to_idle = 1'b0;
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_seq_8086   <= 1'b0;
            r_seq_sp     <= 1'b0;
            r_seq_sngl   <= 1'b0;
            r_casc       <= 1'b0;
            r_match      <= 1'b0;
            r_casc_out   <= '0;
            r_casc_oe    <= 1'b0;
            r_vec_en     <= 1'b0;
            r_vec_sel    <= VSEL_CALL;
            r_seq_active <= 1'b0;
            r_seq_done   <= 1'b0;
            r_seq_abort  <= 1'b0;
        end else begin
            r_seq_done  <= 1'b0;
            r_seq_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state      <= P1;
                        r_cnt        <= '0;
                        r_seq_8086   <= mode_8086;
                        r_seq_sp     <= sp;
                        r_seq_sngl   <= sngl;
                        r_casc       <= w_casc_now;
                        r_match      <= w_match_now;
                        r_casc_out   <= w_casc_now ? intr_id : '0;
                        r_casc_oe    <= w_casc_now;
                        // First 8080 pulse carries CALL; slaves never drive it.
                        r_vec_en     <= ~mode_8086 & (sp | sngl);
                        r_vec_sel    <= VSEL_CALL;
                        r_seq_active <= 1'b1;
                    end
                end
                P1: begin
                    if (w_rise) begin
                        r_state   <= G1;
                        r_cnt     <= '0;
                        r_vec_en  <= 1'b0;
                        r_vec_sel <= VSEL_CALL;
                    end
                end
                G1, G2: begin
                    // A falling edge on the last counted cycle still wins over the timeout.
                    if (w_fall) begin
                        r_state   <= (r_state == G1) ? P2 : P3;
                        r_cnt     <= '0;
                        r_vec_en  <= w_resp;
                        r_vec_sel <= (r_state == G1) ? VSEL_LO : VSEL_HI;
                    end else if (r_cnt == CNT_LAST) begin
                        to_idle = 1'b1;
                        r_seq_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                P2: begin
                    if (w_rise) begin
                        if (r_seq_8086) begin
                            to_idle = 1'b1;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_state   <= G2;
                            r_cnt     <= '0;
                            r_vec_en  <= 1'b0;
                            r_vec_sel <= VSEL_CALL;
                        end
                    end
                end
                P3: begin
                    if (w_rise) begin
                        to_idle = 1'b1;
                        r_seq_done <= 1'b1;
                    end
                end
                default: begin
                    to_idle = 1'b1;
                end
            endcase
            if (to_idle) begin
                r_state      <= IDLE;
                r_cnt        <= '0;
                r_match      <= 1'b0;
                r_casc       <= 1'b0;
                r_casc_out   <= '0;
                r_casc_oe    <= 1'b0;
                r_vec_en     <= 1'b0;
                r_vec_sel    <= VSEL_CALL;
                r_seq_active <= 1'b0;
            end
        end
    end

    assign casc_out   = r_casc_out;
    assign casc_oe    = r_casc_oe;
    assign vec_en     = r_vec_en;
    assign vec_sel    = r_vec_sel;
    assign seq_active = r_seq_active;
    assign seq_done   = r_seq_done;
    assign seq_abort  = r_seq_abort;

endmodule
